// File: rtl/main_memory_responder_if.sv
// Line-transfer bus between the cache controller (master) and the memory responder (slave).
interface main_memory_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  read_en_mem;
    logic                  write_en_mem;
    logic [ADDR_WIDTH-1:0] addr_mem;
    logic [LINE_WIDTH-1:0] wdata_mem;
    logic [LINE_WIDTH-1:0] rdata_mem;
    logic                  ready_mem;
    logic                  busy_mem;
    logic                  proto_err;

    modport master (
        output read_en_mem, write_en_mem, addr_mem, wdata_mem,
        input  rdata_mem, ready_mem, busy_mem, proto_err
    );

    modport slave (
        input  read_en_mem, write_en_mem, addr_mem, wdata_mem,
        output rdata_mem, ready_mem, busy_mem, proto_err
    );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency backing store answering cache line refills and write-backs,
// with a one-cycle ready pulse and a sticky protocol-error flag.
module main_memory_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int DEPTH_LINES   = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input logic                    clk,
    input logic                    rst,
    main_memory_responder_if.slave bus
);
    localparam int OFF     = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W   = $clog2(DEPTH_LINES);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RESPOND = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  commit;
    logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

    // Only the index bits of the address are kept; upper bits alias by design.
    assign commit = !rst && (state == S_WR_WAIT) && bus.write_en_mem && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.write_en_mem) begin
                        idx_q   <= bus.addr_mem[OFF +: IDX_W];
                        wdata_q <= bus.wdata_mem;
                        cnt     <= CNT_W'(WRITE_LATENCY - 1);
                        state   <= S_WR_WAIT;
                        if (bus.read_en_mem) err_q <= 1'b1;
                    end else if (bus.read_en_mem) begin
                        idx_q <= bus.addr_mem[OFF +: IDX_W];
                        cnt   <= CNT_W'(READ_LATENCY - 1);
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!bus.read_en_mem) begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                    end else if (cnt == '0) begin
                        rdata_q <= mem[idx_q];
                        state   <= S_RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (!bus.write_en_mem) begin
                        state <= S_IDLE;
                        err_q <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= S_RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESPOND: state <= S_RELEASE;
                // Hold here until the master lets go, so a held enable cannot re-issue.
                S_RELEASE: if (!bus.read_en_mem && !bus.write_en_mem) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= wdata_q;
    end

    assign bus.rdata_mem = rdata_q;
    assign bus.ready_mem = (state == S_RESPOND);
    assign bus.busy_mem  = (state != S_IDLE);
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized bench for main_memory_responder against a transaction-level line model.
module tb_main_memory_responder;
    localparam int AW = 32, LW = 128, DEPTH = 1024, RL = 4, WL = 4;

    logic clk, rst;
    int   n_chk = 0, n_err = 0;
    logic [LW-1:0] ref_mem [int];
    logic [LW-1:0] last_rd;

    main_memory_responder_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    main_memory_responder #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH_LINES(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lidx(input logic [AW-1:0] a);
        return int'((a / 16) % DEPTH);
    endfunction

    // Issues one request, returns the negedge count at which ready was seen (0 = never).
    task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, output int seen_at);
        int n;
        @(posedge clk); #1;
        bus.write_en_mem = wr;
        bus.read_en_mem  = rd;
        bus.addr_mem     = a;
        bus.wdata_mem    = d;
        seen_at = 0;
        n = 0;
        while (n < 20 && seen_at == 0) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                chk("busy_acc", LW'(bus.busy_mem), 1);
                bus.addr_mem  = $urandom;
                bus.wdata_mem = {4{$urandom}};
            end
            if (bus.ready_mem) seen_at = n;
        end
    endtask

    task automatic finish_xfer();
        @(negedge clk);
        chk("rdy_one_cycle", LW'(bus.ready_mem), 0);
        chk("busy_release", LW'(bus.busy_mem), 1);
        chk("rdata_hold", bus.rdata_mem, last_rd);
        @(posedge clk); #1;
        bus.write_en_mem = 1'b0;
        bus.read_en_mem  = 1'b0;
        @(negedge clk);
        chk("rdy_after", LW'(bus.ready_mem), 0);
        @(negedge clk);
        chk("busy_idle", LW'(bus.busy_mem), 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] d, input bit both);
        int s;
        issue(1'b1, both, a, d, s);
        chk("wr_latency", LW'(s), LW'(WL + 2));
        chk("wr_rdata_keep", bus.rdata_mem, last_rd);
        ref_mem[lidx(a)] = d;
        finish_xfer();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int s;
        issue(1'b0, 1'b1, a, '0, s);
        chk("rd_latency", LW'(s), LW'(RL + 2));
        if (ref_mem.exists(lidx(a))) last_rd = ref_mem[lidx(a)];
        chk("rd_data", bus.rdata_mem, last_rd);
        finish_xfer();
    endtask

    initial begin
        int s, seen;
        logic [AW-1:0] a;
        logic [LW-1:0] old;

        rst = 1'b1;
        bus.read_en_mem = 1'b0; bus.write_en_mem = 1'b0;
        bus.addr_mem = '0; bus.wdata_mem = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", LW'(bus.ready_mem), 0);
        chk("rst_busy", LW'(bus.busy_mem), 0);
        chk("rst_perr", LW'(bus.proto_err), 0);
        chk("rst_rdata", bus.rdata_mem, 0);
        rst = 1'b0;

        // Directed write/read and aliasing
        do_write(32'h40, 128'hDEADBEEF0, 1'b0);
        do_read(32'h40);
        do_read(32'h40 + DEPTH * 16);
        chk("alias_data", bus.rdata_mem, 128'hDEADBEEF0);

        // Write-back followed by refill
        do_write(32'h100, {4{32'h0BAD_F00D}}, 1'b0);
        do_write(32'h80, {4{32'hC0FF_EE11}}, 1'b0);
        do_read(32'h100);
        do_read(32'h80);

        // Randomized traffic over a few lines with random alias/offset bits
        for (int i = 0; i < 24; i++) begin
            a = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 7)) << 4);
            if ($urandom_range(0, 1) == 1 && ref_mem.exists(lidx(a))) do_read(a);
            else do_write(a, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        chk("perr_clean", LW'(bus.proto_err), 0);

        // Both enables in IDLE: write wins, error sticks
        do_write(32'h10, {4{32'h5A5A_A5A5}}, 1'b1);
        chk("perr_both", LW'(bus.proto_err), 1);

        // Read abandoned two cycles into the wait
        @(posedge clk); #1;
        bus.read_en_mem = 1'b1; bus.addr_mem = 32'h10;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.read_en_mem = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ready_mem) seen = 1;
        end
        chk("abort_no_rdy", LW'(seen), 0);
        chk("abort_idle", LW'(bus.busy_mem), 0);
        chk("abort_rdata", bus.rdata_mem, last_rd);
        chk("perr_sticky", LW'(bus.proto_err), 1);
        do_read(32'h10);
        chk("perr_sticky2", LW'(bus.proto_err), 1);

        // Reset while a write waits with two cycles left
        old = ref_mem[lidx(32'h40)];
        @(posedge clk); #1;
        bus.write_en_mem = 1'b1; bus.addr_mem = 32'h40; bus.wdata_mem = ~old;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.ready_mem) seen = 1;
        end
        chk("rstmid_busy", LW'(bus.busy_mem), 1);
        rst = 1'b1;
        bus.write_en_mem = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.ready_mem) seen = 1;
        end
        chk("rstmid_no_rdy", LW'(seen), 0);
        chk("rstmid_idle", LW'(bus.busy_mem), 0);
        chk("rstmid_perr", LW'(bus.proto_err), 0);
        rst = 1'b0;
        last_rd = '0;
        do_read(32'h40);
        chk("rstmid_line", bus.rdata_mem, old);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
